// File: rtl/zbuf_writer.sv
// Depth-tested framebuffer writer: clears depth/colour at frame start, then runs a
// 4-stage read-compare-write pipeline. Optional ZBUF_STATS_EN adds write/reject counters.
module zbuf_writer #(
    parameter int                     FB_HRES     = 320,
    parameter int                     FB_VRES     = 180,
    parameter int                     ZWIDTH      = 16,
    parameter int                     COLOR_WIDTH = 16,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
    localparam int                    NPIX        = FB_HRES * FB_VRES,
    localparam int                    AW          = $clog2(NPIX)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   clear_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [AW-1:0]          addr_in,
    input  logic [ZWIDTH-1:0]      z_in,
    input  logic [COLOR_WIDTH-1:0] color_in,
    input  logic                   last_pixel_in,
    output logic [AW-1:0]          zrd_addr_out,
    input  logic [ZWIDTH-1:0]      zrd_data_in,
    output logic                   zwr_en_out,
    output logic [AW-1:0]          zwr_addr_out,
    output logic [ZWIDTH-1:0]      zwr_data_out,
    output logic                   fbwr_en_out,
    output logic [AW-1:0]          fbwr_addr_out,
    output logic [COLOR_WIDTH-1:0] fbwr_data_out,
    output logic                   frame_done_out
`ifdef ZBUF_STATS_EN
    ,
    output logic [AW:0]            written_count_out,
    output logic [AW:0]            rejected_count_out
`endif
);

    localparam logic [ZWIDTH-1:0] Z_FAR     = {1'b0, {(ZWIDTH-1){1'b1}}};
    localparam logic [AW-1:0]     LAST_ADDR = AW'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AW-1:0]          r_clr_cnt;
    logic                   w_clr_active;
    logic                   w_hazard;
    logic                   w_accept;
    logic                   w_pass;

    logic                   r_v1, r_v2, r_v3;
    logic [AW-1:0]          r_a1, r_a2, r_a3;
    logic [ZWIDTH-1:0]      r_z1, r_z2;
    logic [COLOR_WIDTH-1:0] r_c1, r_c2;

    logic                   r_wr_en;
    logic [AW-1:0]          r_wr_addr;
    logic [ZWIDTH-1:0]      r_wr_z;
    logic [COLOR_WIDTH-1:0] r_wr_c;

    // Stage 3 is included so a new read never races the BRAM write of the same address.
    assign w_hazard = (r_v1 && (r_a1 == addr_in)) ||
                      (r_v2 && (r_a2 == addr_in)) ||
                      (r_v3 && (r_a3 == addr_in));
    assign w_accept     = valid_in && ready_out;
    assign w_pass       = $signed(r_z2) < $signed(zrd_data_in);
    assign zrd_addr_out = w_accept ? addr_in : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        ready_out      = 1'b0;
        frame_done_out = 1'b0;
        w_clr_active   = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_in) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                w_clr_active = 1'b1;
                if (r_clr_cnt == LAST_ADDR) w_state_nxt = RUN;
            end
            RUN: begin
                ready_out = !w_hazard;
                if (valid_in && !w_hazard && last_pixel_in) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!r_v1 && !r_v2 && !r_v3) begin
                    frame_done_out = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_clr_cnt <= '0;
        end else if (r_state == IDLE && clear_in) begin
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR && r_clr_cnt != LAST_ADDR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_a1      <= '0;
            r_a2      <= '0;
            r_a3      <= '0;
            r_z1      <= '0;
            r_z2      <= '0;
            r_c1      <= '0;
            r_c2      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_z    <= '0;
            r_wr_c    <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a1 <= addr_in;
                r_z1 <= z_in;
                r_c1 <= color_in;
            end
            r_v2    <= r_v1;
            r_a2    <= r_a1;
            r_z2    <= r_z1;
            r_c2    <= r_c1;
            r_v3    <= r_v2;
            r_a3    <= r_a2;
            // Read data for stage 2 arrives this cycle; the result is written next cycle.
            r_wr_en <= r_v2 && w_pass;
            if (r_v2) begin
                r_wr_addr <= r_a2;
                r_wr_z    <= r_z2;
                r_wr_c    <= r_c2;
            end
        end
    end

    assign zwr_en_out    = w_clr_active | r_wr_en;
    assign fbwr_en_out   = w_clr_active | r_wr_en;
    assign zwr_addr_out  = w_clr_active ? r_clr_cnt : r_wr_addr;
    assign fbwr_addr_out = w_clr_active ? r_clr_cnt : r_wr_addr;
    assign zwr_data_out  = w_clr_active ? Z_FAR : r_wr_z;
    assign fbwr_data_out = w_clr_active ? CLEAR_COLOR : r_wr_c;

`ifdef ZBUF_STATS_EN
    logic [AW:0] r_written_cnt;
    logic [AW:0] r_rejected_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_written_cnt  <= '0;
            r_rejected_cnt <= '0;
        end else if (r_state == IDLE && clear_in) begin
            r_written_cnt  <= '0;
            r_rejected_cnt <= '0;
        end else if (r_v2) begin
            if (w_pass) begin
                if (r_written_cnt != '1) r_written_cnt <= r_written_cnt + (AW+1)'(1);
            end else begin
                if (r_rejected_cnt != '1) r_rejected_cnt <= r_rejected_cnt + (AW+1)'(1);
            end
        end
    end

    assign written_count_out  = r_written_cnt;
    assign rejected_count_out = r_rejected_cnt;
`endif

endmodule

// File: tb/tb_zbuf_writer.sv
// Scoreboard bench for zbuf_writer: stimulus pushes expected writes, a negedge monitor
// pops and compares every write pulse, including the cycle it appears on.
module tb_zbuf_writer;

    localparam int NPIX = 57600;
    localparam int AW   = 16;

    typedef struct {
        int          addr;
        logic [15:0] z;
        logic [15:0] c;
        int          cyc;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          clear_in;
    logic          valid_in;
    logic          ready_out;
    logic [AW-1:0] addr_in;
    logic [15:0]   z_in;
    logic [15:0]   color_in;
    logic          last_pixel_in;
    logic [AW-1:0] zrd_addr_out;
    logic          zwr_en_out;
    logic [AW-1:0] zwr_addr_out;
    logic [15:0]   zwr_data_out;
    logic          fbwr_en_out;
    logic [AW-1:0] fbwr_addr_out;
    logic [15:0]   fbwr_data_out;
    logic          frame_done_out;

    logic [15:0]   zmem [0:65535];
    logic [15:0]   rd1 = '0;
    logic [15:0]   rd2 = '0;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            fd_count = 0;
    int            fd_cycle = -1;
    exp_t          exp_q[$];
    logic [15:0]   zmodel[int];

    zbuf_writer dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .clear_in       (clear_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .addr_in        (addr_in),
        .z_in           (z_in),
        .color_in       (color_in),
        .last_pixel_in  (last_pixel_in),
        .zrd_addr_out   (zrd_addr_out),
        .zrd_data_in    (rd2),
        .zwr_en_out     (zwr_en_out),
        .zwr_addr_out   (zwr_addr_out),
        .zwr_data_out   (zwr_data_out),
        .fbwr_en_out    (fbwr_en_out),
        .fbwr_addr_out  (fbwr_addr_out),
        .fbwr_data_out  (fbwr_data_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Depth BRAM with two-cycle read latency, read-before-write.
    always @(posedge clk_in) begin
        if (zwr_en_out) zmem[zwr_addr_out] <= zwr_data_out;
        rd1 <= zmem[zrd_addr_out];
        rd2 <= rd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (zwr_en_out || fbwr_en_out) begin
            chk("en_pair", {31'd0, fbwr_en_out}, {31'd0, zwr_en_out});
            chk("addr_pair", {16'd0, fbwr_addr_out}, {16'd0, zwr_addr_out});
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h z 0x%0h at cycle %0d, none expected",
                         zwr_addr_out, zwr_data_out, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", {16'd0, zwr_addr_out}, e.addr);
                chk("wr_z", {16'd0, zwr_data_out}, {16'd0, e.z});
                chk("wr_color", {16'd0, fbwr_data_out}, {16'd0, e.c});
            end
        end
        if (frame_done_out) begin
            fd_count++;
            fd_cycle = cyc;
        end
    end

    function automatic logic [15:0] model_z(input int a);
        return zmodel.exists(a) ? zmodel[a] : 16'h7FFF;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        valid_in      = 1'b0;
        last_pixel_in = 1'b0;
        repeat (n) step();
    endtask

    // Presents one pixel and holds it until accepted; returns acceptance cycle and stall count.
    task automatic send(input int a, input logic [15:0] z, input logic [15:0] c,
                        input logic last, output int t_acc, output int stalls);
        valid_in      = 1'b1;
        addr_in       = a[AW-1:0];
        z_in          = z;
        color_in      = c;
        last_pixel_in = last;
        stalls        = 0;
        t_acc         = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (ready_out) begin
                t_acc = cyc;
                if ($signed(z) < $signed(model_z(a))) begin
                    exp_q.push_back('{a, z, c, cyc + 3});
                    zmodel[a] = z;
                end
                step();
                break;
            end
            stalls++;
            step();
        end
        if (t_acc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: addr %0d never accepted within 20 cycles", a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s, t2, s2, t0, stot, c0;
        rst_n_in      = 1'b0;
        clear_in      = 1'b0;
        valid_in      = 1'b0;
        addr_in       = '0;
        z_in          = '0;
        color_in      = '0;
        last_pixel_in = 1'b0;
        repeat (3) step();
        @(negedge clk_in);
        chk("rst_ready", {31'd0, ready_out}, 0);
        chk("rst_zwr_en", {31'd0, zwr_en_out}, 0);
        chk("rst_fbwr_en", {31'd0, fbwr_en_out}, 0);
        chk("rst_frame_done", {31'd0, frame_done_out}, 0);
        chk("rst_zwr_addr", {16'd0, zwr_addr_out}, 0);
        chk("rst_zwr_data", {16'd0, zwr_data_out}, 0);
        chk("rst_fbwr_addr", {16'd0, fbwr_addr_out}, 0);
        chk("rst_fbwr_data", {16'd0, fbwr_data_out}, 0);
        chk("rst_zrd_addr", {16'd0, zrd_addr_out}, 0);
        step();
        rst_n_in = 1'b1;
        step();
        step();

        valid_in = 1'b1;
        addr_in  = 16'd9;
        @(negedge clk_in);
        chk("idle_ready", {31'd0, ready_out}, 0);
        step();
        idle(1);

        // Full clear; clear_in held an extra cycle into CLEAR must be ignored.
        c0 = cyc;
        for (int i = 0; i < NPIX; i++) exp_q.push_back('{i, 16'h7FFF, 16'h0000, c0 + 1 + i});
        clear_in = 1'b1;
        step();
        step();
        clear_in = 1'b0;
        repeat (NPIX - 2) step();
        @(negedge clk_in);
        chk("clear_busy_ready", {31'd0, ready_out}, 0);
        step();
        @(negedge clk_in);
        chk("ready_after_clear", {31'd0, ready_out}, 1);
        chk("clear_all_written", exp_q.size(), 0);
        step();

        send(100, 16'h0100, 16'hABCD, 1'b0, t, s);
        idle(5);
        send(100, 16'h0200, 16'h1111, 1'b0, t, s);
        idle(5);
        send(100, 16'h0100, 16'h1212, 1'b0, t, s);
        idle(5);
        chk("depth_final_z100", {16'd0, zmem[100]}, 32'h0100);
        send(200, 16'hFFFB, 16'h2222, 1'b0, t, s);
        idle(5);
        send(200, 16'h0003, 16'h2323, 1'b0, t, s);
        idle(5);
        chk("signed_final_z200", {16'd0, zmem[200]}, 32'hFFFB);

        send(5, 16'h0300, 16'h3333, 1'b0, t, s);
        send(5, 16'h0200, 16'h4444, 1'b0, t2, s2);
        chk("hazard_stall", s2, 3);
        chk("hazard_spacing", t2 - t, 4);
        idle(6);
        chk("hazard_final_z5", {16'd0, zmem[5]}, 32'h0200);
        send(6, 16'h0100, 16'h5555, 1'b0, t, s);
        send(6, 16'h0400, 16'h5656, 1'b0, t2, s2);
        chk("hazard_stall_rej", s2, 3);
        idle(6);
        chk("hazard_final_z6", {16'd0, zmem[6]}, 32'h0100);
        send(7, 16'h0050, 16'h7070, 1'b0, t, s);
        send(8, 16'h0060, 16'h8080, 1'b0, t, s);
        send(7, 16'h0040, 16'h7171, 1'b0, t2, s2);
        chk("hazard_stage3_stall", s2, 2);
        idle(6);

        stot = 0;
        t0   = -1;
        for (int i = 0; i < 10; i++) begin
            send(300 + i, 16'(i + 1), 16'(16'h5000 + i), 1'b0, t, s);
            if (i == 0) t0 = t;
            stot += s;
        end
        chk("throughput_stalls", stot, 0);
        chk("throughput_span", t - t0, 9);
        idle(15);

        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        idle(5);
        @(negedge clk_in);
        chk("run_ignores_clear", {31'd0, ready_out}, 1);
        step();

        fd_count = 0;
        send(400, 16'h0010, 16'h6666, 1'b1, t, s);
        valid_in = 1'b1;
        addr_in  = 16'd401;
        z_in     = 16'h0000;
        color_in = 16'h9999;
        last_pixel_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            chk("drain_idle_ready", {31'd0, ready_out}, 0);
            step();
        end
        idle(2);
        chk("frame_done_count", fd_count, 1);
        chk("frame_done_cycle", fd_cycle, t + 4);
        chk("frame_queue_empty", exp_q.size(), 0);

        // Second clear, abandoned by reset while address 1000 is on the write port.
        c0 = cyc;
        for (int i = 0; i < 1000; i++) exp_q.push_back('{i, 16'h7FFF, 16'h0000, c0 + 1 + i});
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        repeat (1000) step();
        #2;
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("rst_clear_zwr_en", {31'd0, zwr_en_out}, 0);
        chk("rst_clear_fbwr_en", {31'd0, fbwr_en_out}, 0);
        chk("rst_clear_ready", {31'd0, ready_out}, 0);
        chk("rst_clear_addr", {16'd0, zwr_addr_out}, 0);
        repeat (3) step();
        rst_n_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk_in);
            chk("post_rst_no_write", {31'd0, zwr_en_out}, 0);
            chk("post_rst_ready", {31'd0, ready_out}, 0);
        end
        chk("rst_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
